data_bus_arbiter: RTL and testbench
===================================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of RESP cycles spent waiting for data_rvalid_i; 0 disables the timeout.
REQ-002 There SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 mK_req_i  input  1  port K (K=0 core LSU, K=1 secondary master) request; held until mK_gnt_o.
REQ-006 mK_gnt_o  output  1  port K request accepted this cycle.
REQ-007 mK_addr_i / mK_we_i / mK_be_i / mK_wdata_i  input  32/1/4/32  port K transaction fields.
REQ-008 mK_rvalid_o  output  1  port K response valid, one-cycle pulse.
REQ-009 mK_rdata_o  output  32  port K read data, valid with mK_rvalid_o.
REQ-010 mK_err_o  output  1  port K response timeout, one-cycle pulse.
REQ-011 data_req_o / data_addr_o / data_we_o / data_be_o / data_wdata_o  output  1/32/1/4/32  shared memory request.
REQ-012 data_gnt_i / data_rvalid_i / data_rdata_i  input  1/1/32  shared memory grant, response and read data.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADDR (request driven, awaiting grant) and RESP (awaiting rvalid); one transaction outstanding at most.
REQ-014 IDLE: a winner SHALL be chosen combinationally among asserted mK_req_i; its fields go to data_* in the same cycle; data_req_o=1.
REQ-015 IDLE with data_gnt_i=1 SHALL assert the winner's mK_gnt_o the same cycle and move to RESP with owner latched; with data_gnt_i=0 it SHALL move to ADDR with owner latched.
REQ-016 ADDR: the owner SHALL be locked, with no re-arbitration even if the other port requests; on data_gnt_i, assert owner gnt and move to RESP.
REQ-017 RESP: data_req_o=0; on data_rvalid_i, pulse owner mK_rvalid_o with mK_rdata_o=data_rdata_i and return to IDLE.
REQ-018 Arbitration SHALL happen only in IDLE, so minimum spacing is grant, rvalid, next grant (2 cycles per transaction with 1-cycle memory).
REQ-019 Timeout: a counter SHALL clear on RESP entry and increment each RESP cycle without rvalid; when it reaches TIMEOUT-1, pulse owner mK_err_o (no rvalid) and go to IDLE.
REQ-020 Simultaneous rvalid and timeout SHALL resolve as rvalid; err_o SHALL NOT assert.
REQ-021 data_rvalid_i in IDLE/ADDR (stray or late) SHALL be dropped; no port sees rvalid.
REQ-022 With no owner and no request, data_* outputs SHALL be 0 and non-owner mK_rdata_o SHALL be 0.
REQ-023 A non-owner SHALL never see gnt, rvalid or err.

Reset
REQ-024 rst_i SHALL force IDLE, owner cleared, counter 0, RR pointer to 1 (port 0 favoured first), and all outputs 0 the same cycle.
REQ-025 Reset mid-ADDR/RESP SHALL abandon the transaction silently; a later rvalid is dropped per REQ-021.

Configuration
REQ-026 Macro DATA_ARB_ROUND_ROBIN_EN defined: on a conflict the port not granted last wins; the pointer updates on each gnt.
REQ-027 Macro undefined: port 0 SHALL always win conflicts and there is no pointer register.

Structure
REQ-028 milano_pkg SHALL hold typedef enum arb_state_e {ARB_IDLE, ARB_ADDR, ARB_RESP}.
REQ-029 Winner selection plus the RR pointer SHALL be sub-module data_arb_sel (inputs req[1:0], update strobe; output one-hot grant).

Verification
REQ-030 m0 alone, addr 0x100, gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF -> m0_gnt_o cycle 0, m0_rvalid_o and m0_rdata_o=0xDEADBEEF cycle 1, m1 untouched.
REQ-031 m0 and m1 requesting every cycle, RR_EN defined -> grants alternate m0,m1,m0,m1; RR_EN undefined -> m0 only, m1 starved.
REQ-032 m1 request, data_gnt_i low 3 cycles -> data_addr_o holds m1 address; an m0 request arriving meanwhile is not granted until after m1's rvalid.
REQ-033 TIMEOUT=4, rvalid withheld -> m0_err_o pulses on RESP cycle 4; a rvalid arriving 2 cycles later is dropped.
REQ-034 rst_i asserted in RESP -> next cycle all outputs 0 and IDLE; pending rvalid dropped; first post-reset conflict granted to m0.
REQ-035 rvalid and timeout in the same cycle -> rvalid delivered, err_o stays 0.

Source files
------------

// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types for the two-port data bus arbiter
package milano_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RESP
    } arb_state_e;

    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/data_arb_sel.sv
// rtl/data_arb_sel.sv - two-port winner select; round-robin pointer under DATA_ARB_ROUND_ROBIN_EN
module data_arb_sel
    import milano_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic [1:0] upd,
    output logic [1:0] gnt
);

`ifdef DATA_ARB_ROUND_ROBIN_EN
    // Index of the port granted most recently; reset to 1 so port 0 wins first.
    logic last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last <= 1'b1;
        end else if (upd[0]) begin
            last <= 1'b0;
        end else if (upd[1]) begin
            last <= 1'b1;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = ^{clk_i, rst_i, upd};

    always_comb begin
        gnt = req;
        if (req[0]) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master single-outstanding data bus arbiter (option: DATA_ARB_ROUND_ROBIN_EN)
module data_bus_arbiter
    import milano_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e       state, state_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       req, sel_gnt, gnt, rvalid, err;
    bus_req_t         port_req [NUM_PORTS];
    bus_req_t         bus;
    logic             bus_req;
    logic             win;
    logic             tmo_hit;

    assign req         = {m1_req_i, m0_req_i};
    assign port_req[0] = {m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i};
    assign port_req[1] = {m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i};
    assign win         = sel_gnt[1];
    assign tmo_hit     = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    data_arb_sel u_sel (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req),
        .upd   (gnt),
        .gnt   (sel_gnt)
    );

    // Outputs are forced quiet while reset is held, not just on the cycle after.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gnt       = '0;
        rvalid    = '0;
        err       = '0;
        bus_req   = 1'b0;
        bus       = '0;
        if (!rst_i) begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        bus_req   = 1'b1;
                        bus       = port_req[win];
                        owner_nxt = win;
                        cnt_nxt   = '0;
                        if (data_gnt_i) begin
                            gnt[win]  = 1'b1;
                            state_nxt = ARB_RESP;
                        end else begin
                            state_nxt = ARB_ADDR;
                        end
                    end
                end
                ARB_ADDR: begin
                    bus_req = 1'b1;
                    bus     = port_req[owner];
                    if (data_gnt_i) begin
                        gnt[owner] = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // rvalid takes priority over a timeout landing in the same cycle.
                    if (data_rvalid_i) begin
                        rvalid[owner] = 1'b1;
                        state_nxt     = ARB_IDLE;
                    end else if (tmo_hit) begin
                        err[owner] = 1'b1;
                        state_nxt  = ARB_IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign m0_gnt_o     = gnt[0];
    assign m1_gnt_o     = gnt[1];
    assign m0_rvalid_o  = rvalid[0];
    assign m1_rvalid_o  = rvalid[1];
    assign m0_err_o     = err[0];
    assign m1_err_o     = err[1];
    assign m0_rdata_o   = rvalid[0] ? data_rdata_i : 32'h0;
    assign m1_rdata_o   = rvalid[1] ? data_rdata_i : 32'h0;
    assign data_req_o   = bus_req;
    assign data_addr_o  = bus.addr;
    assign data_we_o    = bus.we;
    assign data_be_o    = bus.be;
    assign data_wdata_o = bus.wdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we, data_gnt, data_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, data_rdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        data_req, data_we;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;

    int n_chk  = 0;
    int n_fail = 0;
    int last   = 1;

    always #5 clk = ~clk;

    data_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .data_req_o(data_req), .data_addr_o(data_addr), .data_we_o(data_we),
        .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
    );

    function automatic logic [6:0] obs();
        return {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err, data_req};
    endfunction

    // Expected winner: with both requesting, round-robin favours the port not granted last.
    function automatic int pick(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_req = 0; m1_req = 0; data_gnt = 0; data_rvalid = 0; data_rdata = 0;
        m0_we = 0; m1_we = 0; m0_be = 0; m1_be = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1; m0_req = 1; m1_req = 1; m0_addr = 32'h55; data_gnt = 1; data_rvalid = 1;
        data_rdata = 32'hFFFF_0000;
        #1;
        n_chk++;
        if (obs() !== 7'b0 || data_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %b/%h expected 0/0", obs(), data_addr);
        end
        tick(); tick();
        rst = 0; clear_in(); last = 1;
        #1;
        n_chk++;
        if ({data_req, data_addr, data_we, data_be, data_wdata, m0_rdata, m1_rdata} !== '0) begin
            n_fail++; $display("FAIL idle_quiet: got req=%b addr=%h expected all zero", data_req, data_addr);
        end
        tick();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_addr = 32'h100; m0_be = 4'hF; data_gnt = 1;
        #1;
        n_chk++;
        if ({m1_gnt, m0_gnt, data_req} !== 3'b011 || data_addr !== 32'h100) begin
            n_fail++; $display("FAIL single_gnt: got gnt=%b%b addr=%h expected 01/100", m1_gnt, m0_gnt, data_addr);
        end
        last = 0;
        tick();
        m0_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if (obs() !== 7'b0001000 || m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL single_rvalid: got %b rdata=%h expected 0001000 deadbeef", obs(), m0_rdata);
        end
        tick(); clear_in();
    endtask

    task automatic test_conflict();
        int w;
        m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
        for (int t = 0; t < 6; t++) begin
            data_gnt = 1; data_rvalid = 0;
            w = pick(1, 1);
            #1;
            n_chk++;
            if ({m1_gnt, m0_gnt} !== 2'(1 << w) || data_addr !== (w == 1 ? 32'hB0 : 32'hA0)) begin
                n_fail++; $display("FAIL conflict_gnt%0d: got %b%b addr=%h expected port %0d", t, m1_gnt, m0_gnt, data_addr, w);
            end
            last = w;
            tick();
            data_gnt = 0; data_rvalid = 1; data_rdata = 32'h1000 + t;
            #1;
            n_chk++;
            if ({m1_rvalid, m0_rvalid} !== 2'(1 << w)) begin
                n_fail++; $display("FAIL conflict_rv%0d: got %b%b expected port %0d", t, m1_rvalid, m0_rvalid, w);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_addr_hold();
        m1_req = 1; m1_addr = 32'h2000_0040; data_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin m0_req = 1; m0_addr = 32'h300; end
            #1;
            n_chk++;
            if (data_addr !== 32'h2000_0040 || {m1_gnt, m0_gnt} !== 2'b00 || data_req !== 1'b1) begin
                n_fail++; $display("FAIL hold_addr%0d: got addr=%h gnt=%b%b expected 20000040/00", i, data_addr, m1_gnt, m0_gnt);
            end
            tick();
        end
        data_gnt = 1;
        #1;
        n_chk++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL hold_gnt: got %b%b expected 10", m1_gnt, m0_gnt);
        end
        last = 1;
        tick();
        m1_req = 0; data_gnt = 1; data_rvalid = 1; data_rdata = 32'h1234;
        #1;
        n_chk++;
        if (obs() !== 7'b0010000 || m1_rdata !== 32'h1234) begin
            n_fail++; $display("FAIL hold_rvalid: got %b rdata=%h expected 0010000 1234", obs(), m1_rdata);
        end
        tick();
        data_rvalid = 0;
        #1;
        n_chk++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || data_addr !== 32'h300) begin
            n_fail++; $display("FAIL hold_m0_after: got %b%b addr=%h expected 01/300", m1_gnt, m0_gnt, data_addr);
        end
        last = 0;
        tick();
        m0_req = 0; data_gnt = 0; data_rvalid = 1;
        tick(); clear_in();
    endtask

    task automatic test_timeout();
        m0_req = 1; m0_addr = 32'h400; data_gnt = 1;
        #1;
        last = 0;
        tick();
        clear_in();
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_chk++;
            if (obs() !== (c == 4 ? 7'b0000010 : 7'b0)) begin
                n_fail++; $display("FAIL timeout_c%0d: got %b expected err=%0d", c, obs(), c == 4);
            end
            tick();
        end
        tick();
        data_rvalid = 1; data_rdata = 32'hBAD;
        #1;
        n_chk++;
        if (obs() !== 7'b0 || m0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL late_rvalid: got %b rdata=%h expected 0", obs(), m0_rdata);
        end
        tick(); clear_in();
    endtask

    task automatic test_rvalid_timeout();
        m1_req = 1; m1_addr = 32'h500; data_gnt = 1;
        #1;
        last = 1;
        tick();
        clear_in();
        for (int c = 1; c <= 4; c++) begin
            data_rvalid = (c == 4); data_rdata = 32'hCAFE;
            #1;
            n_chk++;
            if (obs() !== (c == 4 ? 7'b0010000 : 7'b0)) begin
                n_fail++; $display("FAIL rv_vs_tmo_c%0d: got %b expected rvalid=%0d err=0", c, obs(), c == 4);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_reset_resp();
        m0_req = 1; m0_addr = 32'h600; data_gnt = 1;
        #1;
        last = 0;
        tick();
        clear_in();
        rst = 1;
        #1;
        n_chk++;
        if (obs() !== 7'b0 || data_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_resp: got %b expected 0", obs());
        end
        tick();
        rst = 0; last = 1; data_rvalid = 1; data_rdata = 32'h77;
        #1;
        n_chk++;
        if (obs() !== 7'b0) begin
            n_fail++; $display("FAIL rst_drop_rvalid: got %b expected 0", obs());
        end
        tick();
        data_rvalid = 0; m0_req = 1; m1_req = 1; data_gnt = 1;
        #1;
        n_chk++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL rst_first_conflict: got %b%b expected 01", m1_gnt, m0_gnt);
        end
        last = 0;
        tick();
        clear_in(); data_rvalid = 1;
        tick(); clear_in();
    endtask

    task automatic test_random();
        bit          busy = 0, granted = 0;
        int          owner = 0, waited = 0, w = 0;
        bit          pend [2] = '{0, 0};
        logic [31:0] addr [2];
        logic [1:0]  e_gnt, e_rv, e_err;
        logic        e_req;
        logic [31:0] e_addr;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1; addr[k] = $urandom;
                end
            end
            m0_req = pend[0]; m1_req = pend[1];
            m0_addr = addr[0]; m1_addr = addr[1];
            data_gnt = $urandom_range(0, 1); data_rvalid = ($urandom_range(0, 3) == 0);
            data_rdata = $urandom;
            e_gnt = 0; e_rv = 0; e_err = 0; e_req = 0; e_addr = 0;
            if (!busy) begin
                if (pend[0] || pend[1]) begin
                    w = pick(pend[0], pend[1]);
                    e_req = 1; e_addr = addr[w];
                    if (data_gnt) e_gnt[w] = 1;
                end
            end else if (!granted) begin
                e_req = 1; e_addr = addr[owner];
                if (data_gnt) e_gnt[owner] = 1;
            end else if (data_rvalid) begin
                e_rv[owner] = 1;
            end else if (waited + 1 == TO) begin
                e_err[owner] = 1;
            end
            #1;
            n_chk++;
            if (obs() !== {e_gnt, e_rv, e_err, e_req} || data_addr !== e_addr ||
                m0_rdata !== (e_rv[0] ? data_rdata : 32'h0) || m1_rdata !== (e_rv[1] ? data_rdata : 32'h0)) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b addr=%h expected %b addr=%h", cyc, obs(), data_addr,
                         {e_gnt, e_rv, e_err, e_req}, e_addr);
            end
            if (!busy) begin
                if (pend[0] || pend[1]) begin
                    busy = 1; owner = w; granted = data_gnt; waited = 0;
                    if (data_gnt) last = w;
                end
            end else if (!granted) begin
                if (data_gnt) begin granted = 1; waited = 0; last = owner; end
            end else if (data_rvalid || waited + 1 == TO) begin
                busy = 0; granted = 0;
            end else begin
                waited++;
            end
            for (int k = 0; k < 2; k++) if (e_gnt[k]) pend[k] = 0;
            tick();
        end
        clear_in();
        tick(); tick(); tick(); tick(); tick();
    endtask

    initial begin
        clear_in();
        rst = 1;
        tick();
        test_reset();
        test_single_read();
        test_conflict();
        test_addr_hold();
        test_timeout();
        test_rvalid_timeout();
        test_reset_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
